// File: rtl/rs232_receiver.sv
// ============================================================================
// Module   : rs232_receiver
// Brief    : UART receive front end, 8N1 (8E1 when RS232_PARITY_EN is defined),
//            mid-bit sampling behind a 2-FF synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rs232_receiver #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd1042
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rs232_rx,
    output logic [7:0] rs232_Data_out,
    output logic       rs232_Data_out_valid,
    output logic       rs232_frame_error,
    output logic       rs232_busy
`ifdef RS232_PARITY_EN
   ,output logic       rs232_parity_error
`endif
);

    localparam logic [15:0] HALF_BIT = CLKS_PER_BIT / 16'd2;
    localparam logic [15:0] c_half_last = HALF_BIT - 16'd1;
    localparam logic [15:0] c_bit_last  = CLKS_PER_BIT - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_rx_s;
    logic        r_rx_p;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
`ifdef RS232_PARITY_EN
    logic        r_parity;
`endif

    logic w_start_edge;
    logic w_half_done;
    logic w_bit_done;

    assign w_start_edge = r_rx_p & ~r_rx_s;
    assign w_half_done  = (r_clk_cnt == c_half_last);
    assign w_bit_done   = (r_clk_cnt == c_bit_last);
    assign rs232_busy   = (r_state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchroniser resets to the idle line level so no false start edge
            r_sync1              <= 1'b1;
            r_rx_s               <= 1'b1;
            r_rx_p               <= 1'b1;
            r_state              <= S_IDLE;
            r_clk_cnt            <= 16'd0;
            r_bit_cnt            <= 3'd0;
            r_shift              <= 8'd0;
            rs232_Data_out       <= 8'd0;
            rs232_Data_out_valid <= 1'b0;
            rs232_frame_error    <= 1'b0;
`ifdef RS232_PARITY_EN
            r_parity             <= 1'b0;
            rs232_parity_error   <= 1'b0;
`endif
        end else begin
            r_sync1              <= rs232_rx;
            r_rx_s               <= r_sync1;
            r_rx_p               <= r_rx_s;
            rs232_Data_out_valid <= 1'b0;
            rs232_frame_error    <= 1'b0;
`ifdef RS232_PARITY_EN
            rs232_parity_error   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_clk_cnt <= 16'd0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_START;
                    end
                end

                S_START: begin
                    if (w_half_done) begin
                        r_clk_cnt <= 16'd0;
                        // A line already back high at mid-start is a glitch
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= 16'd0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef RS232_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

`ifdef RS232_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= 16'd0;
                        r_parity  <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= 16'd0;
                        if (r_rx_s) begin
`ifdef RS232_PARITY_EN
                            if ((^r_shift) ^ r_parity) begin
                                rs232_parity_error <= 1'b1;
                            end else begin
                                rs232_Data_out       <= r_shift;
                                rs232_Data_out_valid <= 1'b1;
                            end
`else
                            rs232_Data_out       <= r_shift;
                            rs232_Data_out_valid <= 1'b1;
`endif
                            r_state <= S_IDLE;
                        end else begin
                            rs232_frame_error <= 1'b1;
                            r_state           <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end

                S_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs232_receiver.sv
// ============================================================================
// Module   : tb_rs232_receiver
// Brief    : Self-checking bench for rs232_receiver with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rs232_receiver;

    localparam logic [15:0] CPB = 16'd16;
    localparam int CPB_I = 16;
    localparam int HALF  = CPB_I / 2;
`ifdef RS232_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LATENCY = 2 + HALF + (FRAME_BITS - 1) * CPB_I + 1;

    localparam int EV_VALID = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_PAR   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs232_rx;
    logic [7:0] rs232_Data_out;
    logic       rs232_Data_out_valid;
    logic       rs232_frame_error;
    logic       rs232_busy;
`ifdef RS232_PARITY_EN
    logic       rs232_parity_error;
`endif

    rs232_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clock                (clk),
        .reset                (rst),
        .rs232_rx             (rs232_rx),
        .rs232_Data_out       (rs232_Data_out),
        .rs232_Data_out_valid (rs232_Data_out_valid),
        .rs232_frame_error    (rs232_frame_error),
        .rs232_busy           (rs232_busy)
`ifdef RS232_PARITY_EN
       ,.rs232_parity_error   (rs232_parity_error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_good = 0;
    int   start_cyc = 0;
    logic prev_valid = 1'b0;
    logic busy_after_valid = 1'bx;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed output pulses, sampled mid-cycle
    always @(negedge clk) begin
        ev_t e;
        if (prev_valid) busy_after_valid = rs232_busy;
        prev_valid = rs232_Data_out_valid;
        e.data = int'(rs232_Data_out);
        e.cyc  = cyc;
        if (rs232_Data_out_valid) begin e.kind = EV_VALID; obs_q.push_back(e); end
        if (rs232_frame_error)    begin e.kind = EV_FRAME; obs_q.push_back(e); end
`ifdef RS232_PARITY_EN
        if (rs232_parity_error)   begin e.kind = EV_PAR;   obs_q.push_back(e); end
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: what a receiver must report for one frame
    task automatic expect_frame(input logic [7:0] b, input logic stop, input logic par);
        ev_t e;
        e.cyc = 0;
        if (!stop) begin
            e.kind = EV_FRAME; e.data = last_good;
`ifdef RS232_PARITY_EN
        end else if (((^b) ^ par) != 1'b0) begin
            e.kind = EV_PAR; e.data = last_good;
`endif
        end else begin
            last_good = int'(b);
            e.kind = EV_VALID; e.data = last_good;
        end
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        repeat (CPB_I) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Callers are always 1 ns after a rising edge, so frames stay cycle aligned
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RS232_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
        expect_frame(b, stop, par);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [7:0] b;
        logic stop, par;

        rst = 1'b1;
        rs232_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  rs232_Data_out, 8'h00);
        check("reset_valid", rs232_Data_out_valid, 1'b0);
        check("reset_ferr",  rs232_frame_error, 1'b0);
        check("reset_busy",  rs232_busy, 1'b0);
        rst = 1'b0;
        idle(5);

        // Single byte, latency and busy release
        send_frame(8'h22, 1'b1, 1'b0);
        idle(4);
        if (obs_q.size() >= 1)
            check("latency_in_window",
                  (obs_q[0].cyc - start_cyc >= LATENCY - 1) && (obs_q[0].cyc - start_cyc <= LATENCY + 1), 1'b1);
        check("busy_after_valid", busy_after_valid, 1'b0);
        compare_events("single");
        check("data_hold", rs232_Data_out, 8'h22);

        // Back-to-back frames with a single stop bit and no gap
        send_frame(8'h23, 1'b1, ^8'h23);
        send_frame(8'h24, 1'b1, ^8'h24);
        idle(4);
        if (obs_q.size() >= 2)
            check("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, FRAME_BITS * CPB_I);
        compare_events("b2b");

        // Short low glitch is rejected at mid-start
        busy_cnt = 0;
        rs232_rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) rs232_rx = 1'b1;
            @(posedge clk);
            #1;
            if (rs232_busy) busy_cnt++;
        end
        check("glitch_busy_seen", busy_cnt > 0, 1'b1);
        check("glitch_busy_bound", busy_cnt <= HALF + 1, 1'b1);
        check("glitch_idle", rs232_busy, 1'b0);
        compare_events("glitch");

        // Framing error followed by a held-low line
        send_frame(8'h22, 1'b1, ^8'h22);
        send_frame(8'h55, 1'b0, ^8'h55);
        rs232_rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("break_wait_busy", rs232_busy, 1'b1);
        check("break_data_kept", rs232_Data_out, 8'h22);
        idle(10);
        check("break_released", rs232_busy, 1'b0);
        send_frame(8'h04, 1'b1, ^8'h04);
        idle(4);
        compare_events("frame_err");

`ifdef RS232_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        idle(4);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(4);
        compare_events("parity");
        check("parity_data", rs232_Data_out, 8'h03);
`endif

        // Asynchronous reset in the middle of data bit 3
        b = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rs232_rx = b[3];
        repeat (HALF) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_data",  rs232_Data_out, 8'h00);
        check("abort_valid", rs232_Data_out_valid, 1'b0);
        check("abort_ferr",  rs232_frame_error, 1'b0);
        check("abort_busy",  rs232_busy, 1'b0);
        rs232_rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_good = 0;
        idle(5);
        compare_events("abort");
        send_frame(8'h04, 1'b1, ^8'h04);
        idle(4);
        compare_events("after_abort");

        // Random frames, some with bad stop bits or parity
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            par  = (^b) ^ ($urandom_range(0, 3) == 0);
            send_frame(b, stop, par);
            if (!stop) idle(3 + int'($urandom_range(0, 20)));
            else       idle(int'($urandom_range(0, 3)));
        end
        idle(5);
        compare_events("random");
        check("random_last_data", rs232_Data_out, last_good[7:0]);
        check("random_idle", rs232_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rs232_receiver.md
Name: rs232_receiver

Overview:
- UART receive front end of the Ackerchip control path: 8N1 serial line in, one byte at a time out to order_control.
- Drives the rs232_Data_out / rs232_Data_out_valid pair that order_control consumes.
- Mid-bit sampling with 2-FF input synchroniser.
- Reports framing errors; optional parity check.

Parameters:
- CLKS_PER_BIT, 16'd1042: clock cycles per bit (10 MHz / 9600 baud); legal range 8..65535.
- HALF_BIT, CLKS_PER_BIT/2: start-bit mid-point offset; derived, do not override.

Ports:
- clock  in  1  system clock (10 MHz).
- reset  in  1  asynchronous, active-high reset.
- rs232_rx  in  1  raw serial line; idle high; asynchronous to clock.
- rs232_Data_out  out  8  last correctly framed byte.
- rs232_Data_out_valid  out  1  one-cycle pulse; rs232_Data_out is new this cycle.
- rs232_frame_error  out  1  one-cycle pulse; stop bit sampled low.
- rs232_busy  out  1  high whenever the FSM is not in IDLE.
- rs232_parity_error  out  1  one-cycle pulse; present only with RS232_PARITY_EN.

Behaviour:
- Reset values:
  - Synchroniser FFs and edge register: 1.
  - All outputs: 0.
  - FSM: IDLE; bit counter 0; clock counter 0; shift register 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately; no output pulse is produced.
- Synchroniser: rs232_rx goes through 2 FFs to give rx_s; rx_p is rx_s delayed by one cycle. A start edge is rx_p=1 and rx_s=0.
- IDLE: on a start edge, load clock counter 0 and go to START.
- START:
  - Count to HALF_BIT-1.
  - At terminal count, if rx_s=0, clear the counter and go to DATA.
  - Otherwise this is a glitch: return to IDLE with no outputs.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample rx_s into the shift register, LSB first (shift right, new bit into bit 7).
  - After the 8th sample go to STOP (or PARITY when enabled).
- PARITY (macro only): after CLKS_PER_BIT cycles, sample rx_s as the parity bit, then go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Sample = 1:
    - Next cycle: rs232_Data_out <= shift register and rs232_Data_out_valid = 1 for exactly one cycle.
    - FSM goes to IDLE in that same cycle, so a start edge on the following cycle is accepted.
  - Sample = 0:
    - rs232_frame_error pulses for one cycle; rs232_Data_out is unchanged; no valid pulse.
    - FSM goes to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 (break / line held low), then go to IDLE. No start is detected while in this state.
- Latency: valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the falling edge on rs232_rx, ±1 cycle of synchroniser phase.
- rs232_Data_out holds its value between valid pulses; downstream may sample it at any time.
- Line low at reset release: the synchroniser sees a 1→0 edge and receives a frame. The stop bit samples 0, giving a frame_error pulse and WAIT_IDLE. This is the defined behaviour.
- Counters saturate nowhere: the clock counter is CLKS_PER_BIT-width and is cleared at each terminal count. The bit counter is 3 bits and wraps exactly at 8 data bits.
- rs232_busy is combinational from the state register (state != IDLE).

Optional Feature:
- Macro RS232_PARITY_EN.
- Defined:
  - Frame is 8E1: the PARITY state is inserted and the rs232_parity_error port exists.
  - Even parity: the XOR of 8 data bits plus the parity bit must be 0.
  - With a good stop bit and bad parity: rs232_parity_error pulses in the cycle valid would have pulsed; valid does not pulse; rs232_Data_out is unchanged; FSM goes to IDLE.
  - Stop bit low takes precedence: frame_error only.
- Undefined: 8N1 framing, no PARITY state, no rs232_parity_error port.

Test Plan:
- CLKS_PER_BIT=16. Send 0x22 (8N1) → one valid pulse; Data_out=0x22; frame_error stays 0; busy returns 0 one cycle after valid.
- Bytes 0x23 then 0x24 back-to-back, single stop bit, no idle gap → two valid pulses exactly 160 cycles apart; Data_out 0x23 then 0x24.
- rs232_rx low for 4 cycles, then high → no valid, no frame_error; busy high at most HALF_BIT+1 cycles; FSM back in IDLE.
- After receiving 0x22, send 0x55 with stop bit low, then hold the line low 40 cycles → one frame_error pulse; Data_out stays 0x22; no start detected until the line goes high; next 0x04 frame is received correctly.
- Reset pulsed during data bit 3 of 0x7E → all outputs 0 immediately, busy 0; subsequent 0x04 frame gives valid with Data_out=0x04.
- RS232_PARITY_EN defined. Send 0x03 with parity bit 1 → parity_error pulse, no valid. Resend with parity 0 → valid, Data_out=0x03.
